// File: rtl/bitmux4to1_rr.sv
// Four-lane round-robin multiplexer with valid/ready handshakes and a registered,
// lane-tagged output stage feeding the 1-to-4 demux (out_a/out_s map onto a/s).
module bitmux4to1_rr #(
    parameter int DW = 2,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4*DW-1:0] in_data,
    input  logic [3:0]      in_valid,
    output logic [3:0]      in_ready,
    output logic [DW-1:0]   out_a,
    output logic [1:0]      out_s,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   beat_cnt
);

    localparam logic [1:0] PTR_RST = 2'd3;

    // Returns {found, lane}: first requesting lane after 'last', wrapping back to 'last' itself.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] lane;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            lane = last + 2'(k);
            if (req[lane]) begin
                rr_pick = {1'b1, lane};
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    function automatic logic [DW-1:0] lane_data(input logic [4*DW-1:0] d, input logic [1:0] k);
        case (k)
            2'd0:    lane_data = d[DW*0 +: DW];
            2'd1:    lane_data = d[DW*1 +: DW];
            2'd2:    lane_data = d[DW*2 +: DW];
            2'd3:    lane_data = d[DW*3 +: DW];
            default: lane_data = {DW{1'b0}};
        endcase
    endfunction

    logic [DW-1:0] out_a_r;
    logic [1:0]    out_s_r;
    logic          out_valid_r;
    logic [1:0]    ptr_r;
    logic [CW-1:0] beat_cnt_r;

    logic          ld_s;
    logic [2:0]    pick_s;
    logic          found_s;
    logic [1:0]    grant_s;
    logic          accept_s;
    logic          xfer_s;
    logic [3:0]    ready_s;

    assign ld_s    = ~out_valid_r | out_ready;
    assign pick_s  = rr_pick(in_valid, ptr_r);
    assign found_s = pick_s[2];
    assign grant_s = pick_s[1:0];
    assign xfer_s  = out_valid_r & out_ready;

    // Grant decode: one-hot ready on the winning lane while the output can load and reset is released.
    always_comb begin
        ready_s  = 4'b0000;
        accept_s = 1'b0;
        if (rst_n && ld_s && found_s) begin
            ready_s  = 4'b0001 << grant_s;
            accept_s = 1'b1;
        end else begin
            ready_s  = 4'b0000;
            accept_s = 1'b0;
        end
    end

    // Output beat register and arbitration pointer; a stall (ld low) holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_r     <= {DW{1'b0}};
            out_s_r     <= 2'd0;
            out_valid_r <= 1'b0;
            ptr_r       <= PTR_RST;
        end else if (accept_s) begin
            out_a_r     <= lane_data(in_data, grant_s);
            out_s_r     <= grant_s;
            out_valid_r <= 1'b1;
            ptr_r       <= grant_s;
        end else if (ld_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Completed output transfers, wrapping naturally at 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= {CW{1'b0}};
        end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign in_ready  = ready_s;
    assign out_a     = out_a_r;
    assign out_s     = out_s_r;
    assign out_valid = out_valid_r;
    assign beat_cnt  = beat_cnt_r;

endmodule
